shift_unit: RTL and testbench

SHIFT_UNIT -- requirements
Module: shift_unit

---
 rtl/shift_unit_pkg.sv | 22 ++
 rtl/shift_unit_step.sv | 27 ++
 rtl/shift_unit.sv | 93 +++++++++
 tb/tb_shift_unit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/shift_unit_pkg.sv
// shift_unit_pkg
//   Shared definitions for the shift unit and the control unit that drives it:
//   operation codes, FSM state encoding and datapath widths.
package shift_unit_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 5;

    // Operation codes; 3'b101..3'b111 are reserved and behave as "hold".
    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_unit_step.sv
// shift_step
//   Combinational single-bit shift/rotate of a 32-bit value.
//   Ports:
//     op      in  3   operation code (reserved codes pass value through)
//     value   in  32  value to step
//     stepped out 32  value after one 1-bit step
module shift_step
    import shift_unit_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] value,
    output logic [DATA_W-1:0] stepped
);

    always_comb begin
        stepped = value;
        case (op)
            OP_SLL:  stepped = {value[DATA_W-2:0], 1'b0};
            OP_SRL:  stepped = {1'b0, value[DATA_W-1:1]};
            OP_SRA:  stepped = {value[DATA_W-1], value[DATA_W-1:1]};
            OP_ROL:  stepped = {value[DATA_W-2:0], value[DATA_W-1]};
            OP_ROR:  stepped = {value[0], value[DATA_W-1:1]};
            default: stepped = value;
        endcase
    end

endmodule

// File: rtl/shift_unit.sv
// shift_unit
//   Multi-cycle shifter: one 1-bit step per clock, shamt steps per operation.
//   Ports:
//     clk      in  1   system clock, rising edge
//     reset_n  in  1   asynchronous active-low reset
//     start    in  1   request pulse, only honoured in IDLE
//     op       in  3   operation code, latched on accepted start
//     data_in  in  32  operand, latched on accepted start
//     shamt    in  5   shift amount, latched on accepted start
//     data_out out 32  result register (partial while busy, valid from done on)
//     busy     out 1   high in SHIFT and DONE
//     done     out 1   one-cycle result-valid strobe
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_IDLE  | waiting for start
//   ST_SHIFT | stepping data_out once per edge, count down
//   ST_DONE  | result valid, done=1, back to IDLE next edge
module shift_unit
    import shift_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CNT_W-1:0]  shamt,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done
);

    state_e            state;
    logic [2:0]        op_q;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] stepped;

    shift_step u_step (
        .op      (op_q),
        .value   (data_out),
        .stepped (stepped)
    );

    // busy and done are registered alongside the state so they are
    // glitch-free and exactly track ST_SHIFT/ST_DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            op_q     <= OP_SLL;
            count    <= '0;
            data_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        data_out <= data_in;
                        op_q     <= op;
                        count    <= shamt;
                        busy     <= 1'b1;
                        if (shamt == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    data_out <= stepped;
                    count    <= count - 1'b1;
                    // Terminal count: this step is the last one.
                    if (count == CNT_W'(1)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_unit.sv
module tb_shift_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic [31:0] data_out;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    shift_unit dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .data_in  (data_in),
        .shamt    (shamt),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Issue one operation, then scramble the inputs to show they are not
    // re-sampled. Checks latency, result, busy/done in DONE and the cycle after.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] d,
                          input logic [4:0] n, input logic [31:0] exp);
        int k;
        op      = o;
        data_in = d;
        shamt   = n;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        data_in = ~d;
        shamt   = ~n;
        op      = 3'b011 ^ o;
        k = 0;
        while (!done && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_latency"}, 32'(k), 32'(n));
        check({tag, "_result"}, data_out, exp);
        check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_done_clear"}, 32'(done), 32'd0);
        check({tag, "_busy_clear"}, 32'(busy), 32'd0);
        check({tag, "_hold"}, data_out, exp);
    endtask

    initial begin
        int done_cnt;
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 3'b000;
        data_in = 32'h0;
        shamt   = 5'd0;
        #12;
        check("reset_data", data_out, 32'h0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("sll4",     3'b000, 32'h0000_0001, 5'd4,  32'h0000_0010);
        run_op("sra31",    3'b010, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
        run_op("srl31",    3'b001, 32'h8000_0000, 5'd31, 32'h0000_0001);
        run_op("ror1",     3'b100, 32'h0000_0001, 5'd1,  32'h8000_0000);
        run_op("rol4",     3'b011, 32'h8000_0001, 5'd4,  32'h0000_0018);
        run_op("srl0",     3'b001, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
        run_op("ror8",     3'b100, 32'h1234_5678, 5'd8,  32'h7812_3456);
        run_op("sra2pos",  3'b010, 32'h4000_0000, 5'd2,  32'h1000_0000);
        run_op("sll31",    3'b000, 32'h0000_0003, 5'd31, 32'h8000_0000);
        run_op("reserved", 3'b101, 32'h1234_5678, 5'd3,  32'h1234_5678);

        // Busy-ignore: extra starts at cycle 3 (SHIFT) and cycle 8 (DONE).
        op      = 3'b000;
        data_in = 32'h0000_0001;
        shamt   = 5'd8;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        done_cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
            if (c == 2) begin
                start   = 1'b1;
                data_in = 32'hFFFF_FFFF;
            end
            if (c == 3) start = 1'b0;
            if (c == 3) check("ignore_busy_shift", 32'(busy), 32'd1);
            if (c == 8) begin
                check("ignore_done_at8", 32'(done), 32'd1);
                start = 1'b1;
            end
            if (c == 9) begin
                start = 1'b0;
                check("ignore_idle_after", 32'(busy), 32'd0);
            end
        end
        check("ignore_result", data_out, 32'h0000_0100);
        check("ignore_done_count", 32'(done_cnt), 32'd1);

        // Reset two cycles into a 20-step operation.
        op      = 3'b000;
        data_in = 32'h0000_0001;
        shamt   = 5'd20;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("midop_busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midop_rst_data", data_out, 32'h0);
        check("midop_rst_busy", 32'(busy), 32'd0);
        check("midop_rst_done", 32'(done), 32'd0);
        done_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check("midop_no_done", 32'(done_cnt), 32'd0);
        reset_n = 1'b1;
        #3;
        run_op("after_rst", 3'b100, 32'h0000_0001, 5'd1, 32'h8000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
